svaunit_vector_player: RTL and testbench

Programmable stimulus player that sits directly upstream of the interface instantiated in an SVAUnit testbench. It drives the per-cycle signal vectors that the interface's assertions check. The test loads a small table of vectors, each with a hold count, then starts playback. The player replays the table for a set number of passes, with start/busy/done handshakes, so a test sequence can produce exact cycle-level patterns for assertions to pass or fail on.

---
 rtl/svaunit_vector_player.sv | 126 ++++++++++++
 tb/tb_svaunit_vector_player.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/svaunit_vector_player.sv
// Table-driven stimulus player: replays loaded {vec, hold} entries for a set
// number of passes, with start/busy/done handshakes and abort.
module svaunit_vector_player #(
  parameter int VEC_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int HOLD_WIDTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [VEC_WIDTH-1:0]  load_vec,
  input  logic [HOLD_WIDTH-1:0] load_hold,
  input  logic [LW-1:0]         length,
  input  logic [7:0]            passes,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  vec_valid,
  output logic [VEC_WIDTH-1:0]  vec_out,
  output logic [AW-1:0]         step_idx,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [1:0] {IDLE, PLAY, FIN} state_t;

  logic [VEC_WIDTH-1:0]  tbl_vec  [DEPTH];
  logic [HOLD_WIDTH-1:0] tbl_hold [DEPTH];

  state_t                state, state_n;
  logic [AW-1:0]         entry, entry_n;
  logic [7:0]            pass, pass_n;
  logic [HOLD_WIDTH-1:0] hold_cnt, hold_n;
  logic [LW-1:0]         len_q, len_n;
  logic [7:0]            passes_q, passes_n;
  logic                  fin_abort;
  logic                  play_n;

  // Table has no reset so its contents survive a reset of the player.
  always_ff @(posedge clock) begin
    if (load_en && !busy) begin
      tbl_vec[load_addr]  <= load_vec;
      tbl_hold[load_addr] <= load_hold;
    end
  end

  always_comb begin
    state_n   = state;
    entry_n   = entry;
    pass_n    = pass;
    hold_n    = hold_cnt;
    len_n     = len_q;
    passes_n  = passes_q;
    fin_abort = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          len_n    = length;
          passes_n = passes;
          entry_n  = '0;
          pass_n   = 8'd1;
          hold_n   = tbl_hold[0];
          state_n  = (length == '0) ? FIN : PLAY;
        end
      end
      PLAY: begin
        if (abort) begin
          state_n   = FIN;
          fin_abort = 1'b1;
        end else if (hold_cnt != '0) begin
          hold_n = hold_cnt - HOLD_WIDTH'(1);
        end else if ({1'b0, entry} != len_q - LW'(1)) begin
          entry_n = entry + AW'(1);
          hold_n  = tbl_hold[entry_n];
        end else if (passes_q != 8'd0 && pass == passes_q) begin
          state_n = FIN;
        end else begin
          // passes=0 loops forever; the pass count saturates instead of wrapping
          entry_n = '0;
          hold_n  = tbl_hold[0];
          if (pass != 8'hFF) pass_n = pass + 8'd1;
        end
      end
      FIN: begin
        state_n = IDLE;
        entry_n = '0;
      end
      default: state_n = IDLE;
    endcase
    play_n = (state_n == PLAY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      entry     <= '0;
      pass      <= '0;
      hold_cnt  <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      busy      <= 1'b0;
      vec_valid <= 1'b0;
      vec_out   <= '0;
      step_idx  <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      entry     <= entry_n;
      pass      <= pass_n;
      hold_cnt  <= hold_n;
      len_q     <= len_n;
      passes_q  <= passes_n;
      busy      <= play_n;
      vec_valid <= play_n;
      vec_out   <= play_n ? tbl_vec[entry_n] : '0;
      step_idx  <= play_n ? entry_n : '0;
      done      <= (state_n == FIN);
      aborted   <= fin_abort;
    end
  end

endmodule

// File: tb/tb_svaunit_vector_player.sv
// Directed bench for svaunit_vector_player: playback, looping, abort,
// boundary lengths, writes while busy and mid-playback reset.
module tb_svaunit_vector_player;

  localparam int AW = 4;
  localparam int LW = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_vec;
  logic [3:0] load_hold;
  logic [4:0] length;
  logic [7:0] passes;
  logic       start;
  logic       abort;
  logic       busy, vec_valid, done, aborted;
  logic [7:0] vec_out;
  logic [3:0] step_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int mvec  [16];
  int mhold [16];
  int seq3  [5] = '{0, 1, 1, 1, 2};

  svaunit_vector_player #(.VEC_WIDTH(8), .DEPTH(16), .HOLD_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_vec(load_vec), .load_hold(load_hold), .length(length),
    .passes(passes), .start(start), .abort(abort), .busy(busy),
    .vec_valid(vec_valid), .vec_out(vec_out), .step_idx(step_idx),
    .done(done), .aborted(aborted)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_play(input string tag, input int idx);
    check({tag, "_valid"}, 32'(vec_valid), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd1);
    check({tag, "_idx"},   32'(step_idx),  32'(idx));
    check({tag, "_vec"},   32'(vec_out),   32'(mvec[idx]));
    check({tag, "_done"},  32'(done),      32'd0);
  endtask

  task automatic expect_done(input string tag, input int ab);
    check({tag, "_fin_done"},  32'(done),      32'd1);
    check({tag, "_fin_abort"}, 32'(aborted),   32'(ab));
    check({tag, "_fin_valid"}, 32'(vec_valid), 32'd0);
    check({tag, "_fin_busy"},  32'(busy),      32'd0);
    check({tag, "_fin_vec"},   32'(vec_out),   32'd0);
    check({tag, "_fin_idx"},   32'(step_idx),  32'd0);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_idle_done"},  32'(done),      32'd0);
    check({tag, "_idle_busy"},  32'(busy),      32'd0);
    check({tag, "_idle_valid"}, 32'(vec_valid), 32'd0);
    check({tag, "_idle_abort"}, 32'(aborted),   32'd0);
  endtask

  task automatic load(input int a, input int v, input int h, input bit upd);
    load_en = 1'b1; load_addr = 4'(a); load_vec = 8'(v); load_hold = 4'(h);
    @(negedge clock);
    load_en = 1'b0;
    if (upd) begin mvec[a] = v; mhold[a] = h; end
  endtask

  // Plays len entries for np passes checking every cycle; inj>=0 issues a
  // write of 0xFF to entry 1 on that playback cycle.
  task automatic play_check(input string tag, input int len, input int np, input int inj);
    int c = 0;
    length = 5'(len); passes = 8'(np); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int p = 0; p < np; p++)
      for (int e = 0; e < len; e++)
        for (int h = 0; h <= mhold[e]; h++) begin
          expect_play(tag, e);
          if (c == inj) begin
            load_en = 1'b1; load_addr = 4'd1; load_vec = 8'hFF; load_hold = 4'd0;
          end else load_en = 1'b0;
          c++;
          @(negedge clock);
        end
    load_en = 1'b0;
    expect_done(tag, 0);
    @(negedge clock);
    expect_idle(tag);
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_vec = '0; load_hold = '0;
    length = '0; passes = '0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 16; i++) begin mvec[i] = 0; mhold[i] = 0; end
    @(negedge clock);
    @(negedge clock);
    expect_idle("reset");
    check("reset_vec", 32'(vec_out), 32'd0);
    check("reset_idx", 32'(step_idx), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    load(0, 8'hA1, 0, 1);
    load(1, 8'hB2, 2, 1);
    load(2, 8'hC3, 0, 1);
    play_check("basic", 3, 1, -1);
    play_check("loop", 3, 3, -1);

    // endless playback then abort after 20 valid cycles
    length = 5'd3; passes = 8'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      expect_play("abort", seq3[c % 5]);
      if (c == 19) abort = 1'b1;
      @(negedge clock);
    end
    abort = 1'b0;
    expect_done("abort", 1);
    @(negedge clock);
    expect_idle("abort_after");

    start = 1'b1; abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      expect_idle("start_abort");
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clock);

    length = 5'd0; passes = 8'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    expect_done("len0", 0);
    @(negedge clock);
    expect_idle("len0_after");

    for (int i = 3; i < 16; i++) load(i, 8'h10 + i, (i == 15) ? 15 : 0, 1);
    play_check("full", 16, 1, -1);

    play_check("busy_wr", 3, 2, 1);
    load(1, 8'hFF, 2, 1);
    play_check("idle_wr", 3, 1, -1);
    load(1, 8'hB2, 2, 1);

    length = 5'd3; passes = 8'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    expect_play("rst_pre0", 0);
    @(negedge clock);
    expect_play("rst_pre1", 1);
    #2 reset = 1'b1;
    #1;
    expect_idle("rst_now");
    check("rst_now_vec", 32'(vec_out), 32'd0);
    check("rst_now_idx", 32'(step_idx), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    expect_idle("rst_after");
    play_check("restart", 3, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
